// File: rtl/led_count_arbiter.sv
// Round-robin owner of one LED step-counter shared by two requesters.
// A clock-enable tick paces the count; each run goes 0..MAX_COUNT and then pulses done.
module led_count_arbiter #(
  parameter int unsigned TICK_DIV  = 1500000,
  parameter int unsigned LED_W     = 4,
  parameter int unsigned MAX_COUNT = 15
) (
  input  logic             clk,
  input  logic             rst_btn,
  input  logic [1:0]       req,
  output logic [1:0]       grant,
  output logic             busy,
  output logic [LED_W-1:0] led,
  output logic [1:0]       done,
  output logic             tick
);

  localparam int unsigned     CntW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TICK_DIV - 1);
  localparam logic [LED_W-1:0] LedMax = LED_W'(MAX_COUNT);

  typedef enum logic {StIdle, StRun} state_e;

  logic [CntW-1:0]  tick_cnt_q;
  logic             tick_q;
  state_e           state_q;
  logic [1:0]       grant_q;
  logic [1:0]       done_q;
  logic [LED_W-1:0] led_q;
  logic             owner_q;
  logic             last_q;
  logic             pick;

  // Free-running divider; never restarted by grants.
  always_ff @(posedge clk) begin
    if (!rst_btn) begin
      tick_cnt_q <= '0;
      tick_q     <= 1'b0;
    end else if (tick_cnt_q == CntLast) begin
      tick_cnt_q <= '0;
      tick_q     <= 1'b1;
    end else begin
      tick_cnt_q <= tick_cnt_q + CntW'(1);
      tick_q     <= 1'b0;
    end
  end

  // On a tie the requester not served last wins; otherwise the lone requester.
  assign pick = (req == 2'b11) ? ~last_q : req[1];

  always_ff @(posedge clk) begin
    if (!rst_btn) begin
      state_q <= StIdle;
      grant_q <= 2'b00;
      done_q  <= 2'b00;
      led_q   <= '0;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      done_q <= 2'b00;
      case (state_q)
        StIdle: begin
          if (req != 2'b00) begin
            owner_q <= pick;
            grant_q <= pick ? 2'b10 : 2'b01;
            led_q   <= '0;
            state_q <= StRun;
          end
        end
        StRun: begin
          // Terminal test comes before the increment, so led never passes LedMax.
          if (tick_q) begin
            if (led_q == LedMax) begin
              led_q           <= '0;
              done_q[owner_q] <= 1'b1;
              grant_q         <= 2'b00;
              last_q          <= owner_q;
              state_q         <= StIdle;
            end else begin
              led_q <= led_q + LED_W'(1);
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign grant = grant_q;
  assign busy  = |grant_q;
  assign led   = led_q;
  assign done  = done_q;
  assign tick  = tick_q;

endmodule

// File: tb/tb_led_count_arbiter.sv
// Self-checking bench for led_count_arbiter: a constant vector table for one run,
// directed corner sequences, and random traffic against a cycle-counting model.
module tb_led_count_arbiter;

  localparam int unsigned TICK_DIV  = 4;
  localparam int unsigned LED_W     = 4;
  localparam int unsigned MAX_COUNT = 3;

  logic             clk = 1'b0;
  logic             rst_btn = 1'b0;
  logic [1:0]       req = 2'b00;
  logic [1:0]       grant;
  logic             busy;
  logic [LED_W-1:0] led;
  logic [1:0]       done;
  logic             tick;

  int n_checks = 0;
  int n_fail   = 0;

  led_count_arbiter #(
    .TICK_DIV (TICK_DIV),
    .LED_W    (LED_W),
    .MAX_COUNT(MAX_COUNT)
  ) dut (
    .clk    (clk),
    .rst_btn(rst_btn),
    .req    (req),
    .grant  (grant),
    .busy   (busy),
    .led    (led),
    .done   (done),
    .tick   (tick)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d",
             n_checks, n_fail);
    $fatal(1);
  end

  // Reference model: edges since reset, the current owner, and ticks consumed by the run.
  int         m_cycles;
  int         m_owner;
  int         m_ticks;
  int         m_last;
  logic [1:0] e_grant;
  logic [1:0] e_done;
  int         e_led;
  logic       e_tick;

  task automatic model_edge(input logic [1:0] r, input logic rb);
    logic prev_tick;
    if (!rb) begin
      m_cycles = 0;
      m_owner  = -1;
      m_ticks  = 0;
      m_last   = 1;
      e_done   = 2'b00;
      e_tick   = 1'b0;
    end else begin
      prev_tick = e_tick;
      e_done    = 2'b00;
      m_cycles++;
      e_tick = ((m_cycles % TICK_DIV) == 0);
      if (m_owner < 0) begin
        if (r == 2'b01) m_owner = 0;
        else if (r == 2'b10) m_owner = 1;
        else if (r == 2'b11) m_owner = 1 - m_last;
        m_ticks = 0;
      end else if (prev_tick) begin
        if (m_ticks == MAX_COUNT) begin
          e_done[m_owner] = 1'b1;
          m_last  = m_owner;
          m_owner = -1;
          m_ticks = 0;
        end else begin
          m_ticks++;
        end
      end
    end
    e_grant = (m_owner < 0) ? 2'b00 : (2'b01 << m_owner);
    e_led   = m_ticks;
  endtask

  task automatic check(input string name, input logic [1:0] g, input logic [LED_W-1:0] l,
                       input logic [1:0] d, input logic t);
    n_checks++;
    if (grant !== g || busy !== (|g) || led !== l || done !== d || tick !== t) begin
      n_fail++;
      $display("FAIL %s @%0t: got grant=%b busy=%b led=%0d done=%b tick=%b, want grant=%b busy=%b led=%0d done=%b tick=%b",
               name, $time, grant, busy, led, done, tick, g, |g, l, d, t);
    end
  endtask

  task automatic step(input logic [1:0] r, input logic rb);
    @(negedge clk);
    req     = r;
    rst_btn = rb;
    @(posedge clk);
    model_edge(r, rb);
    #1;
    check("model", e_grant, LED_W'(e_led), e_done, e_tick);
  endtask

  task automatic expect_true(input string name, input logic cond, input int got, input int want);
    n_checks++;
    if (!cond) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  typedef struct {
    logic             rb;
    logic [1:0]       req;
    logic [1:0]       g;
    logic [LED_W-1:0] led;
    logic [1:0]       d;
    logic             t;
  } vec_t;

  vec_t vecs[19];

  initial begin
    logic [1:0] grants[$];
    logic [1:0] prev_grant;
    int         cnt;
    int         dones;
    int         bad_done;

    // Single run after reset: req=01 for one cycle, then released.
    vecs[0] = '{1'b0, 2'b00, 2'b00, 4'd0, 2'b00, 1'b0};
    vecs[1] = '{1'b1, 2'b01, 2'b01, 4'd0, 2'b00, 1'b0};
    for (int i = 2; i <= 16; i++)
      vecs[i] = '{1'b1, 2'b00, 2'b01, LED_W'((i - 1) / 4), 2'b00, ((i % 4) == 0)};
    vecs[17] = '{1'b1, 2'b00, 2'b00, 4'd0, 2'b01, 1'b0};
    vecs[18] = '{1'b1, 2'b00, 2'b00, 4'd0, 2'b00, 1'b0};

    for (int i = 0; i < 19; i++) begin
      step(vecs[i].req, vecs[i].rb);
      check($sformatf("vec%0d", i), vecs[i].g, vecs[i].led, vecs[i].d, vecs[i].t);
    end

    // Idle with no requests: outputs stay 0 while tick keeps pulsing every 4 cycles.
    step(2'b00, 1'b0);
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      step(2'b00, 1'b1);
      if (tick) cnt++;
    end
    expect_true("idle_tick_count", cnt == 4, cnt, 4);

    // Tie after reset: strict alternation 01, 10, 01.
    step(2'b00, 1'b0);
    prev_grant = 2'b00;
    for (int i = 0; i < 200 && grants.size() < 3; i++) begin
      step(2'b11, 1'b1);
      if (grant != 2'b00 && prev_grant == 2'b00) grants.push_back(grant);
      prev_grant = grant;
    end
    expect_true("tie_grant_count", grants.size() == 3, grants.size(), 3);
    if (grants.size() == 3) begin
      expect_true("tie_first",  grants[0] == 2'b01, grants[0], 1);
      expect_true("tie_second", grants[1] == 2'b10, grants[1], 2);
      expect_true("tie_third",  grants[2] == 2'b01, grants[2], 1);
    end

    // Same requester held: back-to-back runs, each ending with done=01.
    step(2'b00, 1'b0);
    dones = 0;
    bad_done = 0;
    for (int i = 0; i < 100 && dones < 2; i++) begin
      step(2'b01, 1'b1);
      if (done == 2'b01) dones++;
      if (done == 2'b10) bad_done++;
    end
    expect_true("repeat_dones", dones == 2, dones, 2);
    expect_true("repeat_no_other_done", bad_done == 0, bad_done, 0);

    // Owner withdraws mid-run at led=1; the run still completes.
    step(2'b00, 1'b0);
    step(2'b01, 1'b1);
    for (int i = 0; i < 40 && led != 1; i++) step(2'b01, 1'b1);
    expect_true("withdraw_reach_led1", led == 1, led, 1);
    cnt = 0;
    dones = 0;
    for (int i = 0; i < 40 && dones == 0; i++) begin
      step(2'b00, 1'b1);
      if (led == MAX_COUNT) cnt = 1;
      if (done == 2'b01) dones++;
    end
    expect_true("withdraw_saw_max", cnt == 1, cnt, 1);
    expect_true("withdraw_done", dones == 1, dones, 1);

    // Reset mid-run at led=2: aborted silently, then req=11 grants 01 first.
    step(2'b00, 1'b0);
    step(2'b10, 1'b1);
    for (int i = 0; i < 40 && led != 2; i++) step(2'b00, 1'b1);
    expect_true("abort_reach_led2", led == 2, led, 2);
    step(2'b00, 1'b0);
    check("abort_reset", 2'b00, '0, 2'b00, 1'b0);
    dones = 0;
    for (int i = 0; i < 30; i++) begin
      step(2'b00, 1'b1);
      if (done != 2'b00) dones++;
    end
    expect_true("abort_no_done", dones == 0, dones, 0);
    step(2'b11, 1'b1);
    check("abort_tie_grant", 2'b01, '0, 2'b00, tick);

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++)
      step(2'($urandom), ($urandom_range(0, 299) != 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/led_count_arbiter.md
# led_count_arbiter

Shares one LED step-counter between two requesters on a single clock domain. It replaces the divided-clock style with a clock-enable tick. A round-robin arbiter grants the counter to one requester at a time and runs it from 0 to MAX_COUNT, one step per tick. It then pulses that requester's done line and releases the counter. The block sits between the conditioned button/request logic and the board LEDs.

## Interface
Parameters:
- TICK_DIV, 1500000: clk cycles per count tick; legal range ≥1 (1 = tick every cycle).
- LED_W, 4: width of the counter/LED bus.
- MAX_COUNT, 15: terminal count; must be < 2^LED_W.

Ports:
- clk  input  1  sole clock; all logic on posedge.
- rst_btn  input  1  reset, synchronous, active-low.
- req  input  2  level requests, active-high, already synchronised/inverted upstream.
- grant  output  2  one-hot owner of the counter; 00 when idle.
- busy  output  1  high while a run is in progress (= |grant).
- led  output  LED_W  current count of the active run; 0 when idle.
- done  output  2  one-cycle pulse on the bit of the requester whose run just finished.
- tick  output  1  one-cycle count-enable pulse (exported for debug/other consumers).

## Operation
- Reset (rst_btn low at a clk edge): grant=00, busy=0, led=0, done=00, tick=0. Also tick counter=0, state=IDLE, last_served=1, so req[0] wins the first tie.
- Tick generator: a free-running counter of width max(1,clog2(TICK_DIV)) counts 0..TICK_DIV-1 and wraps. tick is registered high for exactly one cycle each time the counter wraps. The generator runs in every state and is not restarted by grants.
- FSM states: IDLE and RUN.
- IDLE:
  - If req==00, stay in IDLE.
  - If exactly one req bit is set, grant that bit.
  - If req==11, grant the bit that is not last_served.
  - On grant: state→RUN, led←0.
- RUN:
  - On each tick with led<MAX_COUNT: led←led+1.
  - On a tick with led==MAX_COUNT: led←0, done[owner]←1 for one cycle, grant←00, last_served←owner, state→IDLE.
- req changes during RUN, including the owner dropping its request, are ignored. A run always completes.
- A tick only advances led in RUN. A tick coinciding with the granting edge is not counted.
- The just-served requester is re-granted only if the other requester is not asserting req in the IDLE cycle.
- Count arithmetic is LED_W bits unsigned. It never wraps past MAX_COUNT because the terminal test precedes the increment.

## Timing
- Grant latency: req sampled high in IDLE at edge k gives grant/busy high in the cycle after edge k, with led=0.
- Run length: led holds 0 until the first tick in RUN, then steps once per tick. The run ends on the (MAX_COUNT+1)-th tick after grant, spanning roughly (MAX_COUNT+1)×TICK_DIV cycles.
- done: asserted in the cycle after the terminal-tick edge. In that same cycle grant=00, busy=0 and led=0.
- Back-to-back: the done cycle is IDLE and samples req. The next grant is visible one cycle after done, giving a minimum one-cycle gap with busy=0.
- Reset mid-run: the run is aborted with no done pulse. All outputs are at reset values in the cycle after the reset edge. last_served returns to 1.
- No combinational path from req to any output. All outputs are registered.

## Test plan
All scenarios use TICK_DIV=4, MAX_COUNT=3, LED_W=4.
- Reset then idle, req=00: all outputs 0 indefinitely, and tick pulses every 4 cycles.
- Single run, req=01 held one cycle then dropped: grant=01 next cycle; led steps 0→1→2→3 on ticks; on the 4th tick done=01 for one cycle; grant=00, led=0.
- Tie after reset, req=11 held: first grant=01; after done, grant=10 one cycle later; then 01 again (strict alternation).
- Same requester repeating, req=01 held continuously, req[1]=0: consecutive runs granted to 01, each separated by exactly one busy=0 cycle, each ending with done=01.
- Mid-run withdrawal: owner drops req while led=1; the run still reaches 3 and pulses done.
- Reset mid-run: assert rst_btn=0 for one edge while led=2. The next cycle has grant=00, led=0, done=00, and no done pulse follows. A later req=11 grants 01 first.
